control_unit: RTL
=================

# control_unit

Control unit (FSM) for the six-instruction processor. It fetches 16-bit instructions from instruction memory, holds the PC and IR, and decodes each instruction into the control signals the operational block consumes: register-file addresses and strobes, W_data mux select, ALU select and the 8-bit constant. It also drives data-memory address and strobes, and reads back `rf_rp_zero` for conditional jumps. It sits between instruction memory and the datapath/data-memory pair.

## Interface
- `WIDTH`, 16, instruction and data word width
- `REGBITS`, 4, register-file address width
- `PCBITS`, 16, program counter / instruction address width
- `clk` input 1, single clock; all state updates on rising edge
- `rst_n` input 1, reset; asynchronous, active-low
- `i_addr` output PCBITS, instruction memory address (= PC)
- `i_rd` output 1, instruction read strobe
- `i_data` input WIDTH, instruction word; asynchronous-read, valid in the same cycle as `i_rd`
- `d_addr` output 8, data memory address
- `d_rd`, `d_wr` output 1 each, data memory strobes
- `rf_w_data` output 8, constant for LDC
- `rf_w_addr`, `rf_rp_addr`, `rf_rq_addr` output REGBITS each, register addresses
- `rf_w_wr`, `rf_rp_rd`, `rf_rq_rd` output 1 each, register-file strobes
- `rf_s` output 2, W_data select: 00 ALU, 01 data memory, 10 constant
- `alu_s` output 2, ALU operation: 00 bypass, 01 add, 10 sub
- `rf_rp_zero` input 1, Rp-port data equals zero
- `halted` output 1, processor stopped (driven 0 unless `HALT_EN`)

## Operation
- Instruction fields: op = IR[15:12], ra = IR[11:8], rb = IR[7:4], rc = IR[3:0], d = IR[7:0], off = IR[7:0] (signed).
- States: INIT, FETCH, DECODE, LOAD, STORE, ADD, LDC, SUB, JMPZ, JMPZ_JMP, plus HALT under `HALT_EN`.
- INIT: PC ← 0; go to FETCH.
- FETCH: `i_rd`=1, `i_addr`=PC, IR ← `i_data`, PC ← PC+1; go to DECODE.
- DECODE: no strobes. Branch on op: 0000 LOAD, 0001 STORE, 0010 ADD, 0011 LDC, 0100 SUB, 0101 JMPZ. Any other op goes to FETCH as a NOP.
- LOAD: `d_addr`=d, `d_rd`=1, `rf_s`=01, `rf_w_addr`=ra, `rf_w_wr`=1.
- STORE: `d_addr`=d, `d_wr`=1, `rf_rp_addr`=ra, `rf_rp_rd`=1.
- ADD/SUB: `rf_rp_addr`=rb, `rf_rq_addr`=rc, both read strobes 1, `alu_s`=01/10, `rf_s`=00, `rf_w_addr`=ra, `rf_w_wr`=1.
- LDC: `rf_w_data`=d, `rf_s`=10, `rf_w_addr`=ra, `rf_w_wr`=1.
- JMPZ: `rf_rp_addr`=ra, `rf_rp_rd`=1. If `rf_rp_zero`=1, go to JMPZ_JMP; otherwise go to FETCH.
- JMPZ_JMP: PC ← PC + sext(off) − 1, so the target is the JMPZ address plus off.
- Every execute state returns to FETCH.
- PC arithmetic is modulo 2^PCBITS: increment of all-ones wraps to 0, and negative offsets wrap.
- Outputs are Moore, decoded from state and IR only. Every output not listed for a state is 0 (addresses 0, selects 00).
- `d_rd` and `d_wr` are never both 1. `rf_w_wr` is never 1 outside LOAD/ADD/SUB/LDC.

## Timing
- Reset values: state INIT, PC 0, IR 0, every output 0.
- Reset is asynchronous. Asserting `rst_n` mid-instruction forces the reset values immediately, and the in-flight register or memory write is suppressed.
- After `rst_n` deasserts: 1 cycle INIT, then FETCH with `i_addr`=0.
- Cycle counts: 3 cycles per instruction (FETCH, DECODE, execute); taken JMPZ is 4; NOP is 2.
- Execute-state writes commit on the rising edge that ends the execute cycle.
- `rf_rp_zero` is sampled at the end of the JMPZ cycle only.

## Configuration
- `CONTROL_HALT_EN` defined:
  - op 1111 goes DECODE→HALT.
  - HALT holds all strobes at 0 with PC frozen and `halted`=1, until reset.
- Not defined:
  - No HALT state exists and op 1111 is a NOP.
  - `halted` is tied to 0.

## Test plan
- Reset: hold `rst_n`=0 during an ADD execute cycle → `rf_w_wr` drops to 0 immediately, `i_addr`=0. After release, INIT for 1 cycle, then FETCH with `i_addr`=0, `i_rd`=1.
- LDC 0x322A at PC 0 → execute cycle: `rf_w_wr`=1, `rf_w_addr`=2, `rf_s`=10, `rf_w_data`=0x2A. Next FETCH has `i_addr`=1.
- ADD 0x2312 → `rf_w_addr`=3, `rf_rp_addr`=1, `rf_rq_addr`=2, `rf_rp_rd`=`rf_rq_rd`=1, `alu_s`=01, `rf_s`=00. SUB 0x4312 → same with `alu_s`=10.
- LOAD 0x0705 → `d_addr`=0x05, `d_rd`=1, `rf_s`=01, `rf_w_addr`=7. STORE 0x1405 → `d_addr`=0x05, `d_wr`=1, `rf_rp_addr`=4, `rf_w_wr`=0.
- JMPZ 0x51FE at address 10:
  - `rf_rp_zero`=1 → JMPZ_JMP, next `i_addr`=8, 4 cycles total.
  - `rf_rp_zero`=0 → next `i_addr`=11.
  - JMPZ at 0xFFFF with off=+1 → target 0x0000.
- Op 0xF000 with `CONTROL_HALT_EN` → `halted`=1 permanently, `i_rd`=0. Without the macro → NOP, next `i_addr`=PC+1 after 2 cycles.

Source files
------------

// File: rtl/control_unit.sv
// control_unit -- fetch/decode/execute sequencer for the six-instruction
// processor. Holds PC and IR, fetches from an asynchronous-read instruction
// memory and decodes each instruction into Moore control outputs for the
// register file, ALU, W_data mux and data memory.
//
// Optional feature macro: CONTROL_HALT_EN
//   defined   -> op 1111 enters a terminal HALT state (halted=1, PC frozen)
//   undefined -> op 1111 is a NOP, halted is tied to 0
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   i_addr, i_rd, i_data        instruction memory address/strobe/word
//   d_addr, d_rd, d_wr          data memory address and strobes
//   rf_w_data                   8-bit constant for LDC
//   rf_w_addr/rp_addr/rq_addr   register-file addresses
//   rf_w_wr/rp_rd/rq_rd         register-file strobes
//   rf_s                        W_data select (00 ALU, 01 dmem, 10 const)
//   alu_s                       ALU op (00 bypass, 01 add, 10 sub)
//   rf_rp_zero                  Rp-port data is zero (for JMPZ)
//   halted                      processor stopped
module control_unit #(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4,
  parameter int PCBITS  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PCBITS-1:0]  i_addr,
  output logic               i_rd,
  input  logic [WIDTH-1:0]   i_data,
  output logic [7:0]         d_addr,
  output logic               d_rd,
  output logic               d_wr,
  output logic [7:0]         rf_w_data,
  output logic [REGBITS-1:0] rf_w_addr,
  output logic [REGBITS-1:0] rf_rp_addr,
  output logic [REGBITS-1:0] rf_rq_addr,
  output logic               rf_w_wr,
  output logic               rf_rp_rd,
  output logic               rf_rq_rd,
  output logic [1:0]         rf_s,
  output logic [1:0]         alu_s,
  input  logic               rf_rp_zero,
  output logic               halted
);

  typedef enum logic [3:0] {
    S_INIT, S_FETCH, S_DECODE, S_LOAD, S_STORE, S_ADD,
    S_LDC, S_SUB, S_JMPZ, S_JMPZ_JMP
`ifdef CONTROL_HALT_EN
    , S_HALT
`endif
  } state_t;

  state_t             state, state_next;
  logic [PCBITS-1:0]  pc;
  logic [WIDTH-1:0]   ir;

  // Instruction fields
  logic [3:0]         op;
  logic [REGBITS-1:0] ra, rb, rc;
  logic [7:0]         d;
  logic signed [7:0]  off;

  assign op  = ir[15:12];
  assign ra  = REGBITS'(ir[11:8]);
  assign rb  = REGBITS'(ir[7:4]);
  assign rc  = REGBITS'(ir[3:0]);
  assign d   = ir[7:0];
  assign off = signed'(ir[7:0]);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_INIT;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_INIT:     pc <= '0;
        S_FETCH: begin
          ir <= i_data;
          pc <= pc + 1'b1;
        end
        // PC already points past the JMPZ, so subtract one to land on
        // JMPZ address + off. Sign-extending cast; wraps modulo 2^PCBITS.
        S_JMPZ_JMP: pc <= pc + PCBITS'(off) - 1'b1;
        default:    ;
      endcase
    end
  end

  // Next-state and Moore outputs.
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    i_addr     = '0;
    i_rd       = 1'b0;
    d_addr     = '0;
    d_rd       = 1'b0;
    d_wr       = 1'b0;
    rf_w_data  = '0;
    rf_w_addr  = '0;
    rf_rp_addr = '0;
    rf_rq_addr = '0;
    rf_w_wr    = 1'b0;
    rf_rp_rd   = 1'b0;
    rf_rq_rd   = 1'b0;
    rf_s       = 2'b00;
    alu_s      = 2'b00;
    halted     = 1'b0;

    case (state)
      S_INIT:  state_next = S_FETCH;
      S_FETCH: begin
        i_addr     = pc;
        i_rd       = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        case (op)
          4'b0000: state_next = S_LOAD;
          4'b0001: state_next = S_STORE;
          4'b0010: state_next = S_ADD;
          4'b0011: state_next = S_LDC;
          4'b0100: state_next = S_SUB;
          4'b0101: state_next = S_JMPZ;
`ifdef CONTROL_HALT_EN
          4'b1111: state_next = S_HALT;
`endif
          default: state_next = S_FETCH;  // unused opcodes are NOPs
        endcase
      end
      S_LOAD: begin
        d_addr     = d;
        d_rd       = 1'b1;
        rf_s       = 2'b01;
        rf_w_addr  = ra;
        rf_w_wr    = 1'b1;
        state_next = S_FETCH;
      end
      S_STORE: begin
        d_addr     = d;
        d_wr       = 1'b1;
        rf_rp_addr = ra;
        rf_rp_rd   = 1'b1;
        state_next = S_FETCH;
      end
      S_ADD, S_SUB: begin
        rf_rp_addr = rb;
        rf_rq_addr = rc;
        rf_rp_rd   = 1'b1;
        rf_rq_rd   = 1'b1;
        alu_s      = (state == S_ADD) ? 2'b01 : 2'b10;
        rf_s       = 2'b00;
        rf_w_addr  = ra;
        rf_w_wr    = 1'b1;
        state_next = S_FETCH;
      end
      S_LDC: begin
        rf_w_data  = d;
        rf_s       = 2'b10;
        rf_w_addr  = ra;
        rf_w_wr    = 1'b1;
        state_next = S_FETCH;
      end
      S_JMPZ: begin
        rf_rp_addr = ra;
        rf_rp_rd   = 1'b1;
        state_next = rf_rp_zero ? S_JMPZ_JMP : S_FETCH;
      end
      S_JMPZ_JMP: state_next = S_FETCH;
`ifdef CONTROL_HALT_EN
      S_HALT: begin
        halted     = 1'b1;
        state_next = S_HALT;
      end
`endif
      default: state_next = S_INIT;
    endcase
  end

endmodule
